// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: entry payload layout, tag width and the flag
// bit positions that RegRead decodes from the same 23-bit bundle.
package issue_queue_pkg;

   localparam int IQ_FLAGS_W = 23;
   localparam int PHYS_TAG_W = 6;

   localparam int FLAG_MEM_READ           = 22;
   localparam int FLAG_MULT_REG_ACCESS_HI = 1;
   localparam int FLAG_MULT_REG_ACCESS_LO = 0;

   typedef struct packed {
      logic [31:0]            uid;
      logic [31:0]            instr;
      logic [31:0]            pc;
      logic [31:0]            pc_plus4;
      logic [IQ_FLAGS_W-1:0]  flags;
      logic [PHYS_TAG_W-1:0]  rs;
      logic [PHYS_TAG_W-1:0]  rt;
      logic [PHYS_TAG_W-1:0]  rd;
   } iq_entry_t;

   function automatic logic wb_hit(input logic                  wb_vld,
                                   input logic [PHYS_TAG_W-1:0] wb_tag,
                                   input logic [PHYS_TAG_W-1:0] tag);
      return wb_vld && (wb_tag == tag);
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and issue bundle between rename/dispatch, writeback and RegRead.
// master = the surrounding pipeline, slave = the issue queue.
interface issue_queue_if
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  flush;
   logic                  disp_valid;
   logic [31:0]           disp_UID;
   logic [31:0]           disp_Instr;
   logic [31:0]           disp_PC;
   logic [31:0]           disp_PC_Plus4;
   logic [IQ_FLAGS_W-1:0] disp_Flags;
   logic [PHYS_TAG_W-1:0] disp_rs;
   logic [PHYS_TAG_W-1:0] disp_rt;
   logic [PHYS_TAG_W-1:0] disp_rd;
   logic                  disp_rs_ready;
   logic                  disp_rt_ready;
   logic                  RegWrite_fMM;
   logic [PHYS_TAG_W-1:0] WriteRegister_fMM;

   logic                  iq_full;
   logic [CW-1:0]         iq_count;
   logic                  iq_empty;
   logic [31:0]           Instr_UID_out;
   logic [31:0]           Instr_out;
   logic [31:0]           Instr_PC_out;
   logic [31:0]           Instr_PC_Plus4_out;
   logic [IQ_FLAGS_W-1:0] Instr_Flags_out;
   logic [PHYS_TAG_W-1:0] rs_out;
   logic [PHYS_TAG_W-1:0] rt_out;
   logic [PHYS_TAG_W-1:0] rd_out;

   modport master (
      output flush, disp_valid, disp_UID, disp_Instr, disp_PC, disp_PC_Plus4, disp_Flags,
             disp_rs, disp_rt, disp_rd, disp_rs_ready, disp_rt_ready,
             RegWrite_fMM, WriteRegister_fMM,
      input  iq_full, iq_count, iq_empty, Instr_UID_out, Instr_out, Instr_PC_out,
             Instr_PC_Plus4_out, Instr_Flags_out, rs_out, rt_out, rd_out
   );

   modport slave (
      input  flush, disp_valid, disp_UID, disp_Instr, disp_PC, disp_PC_Plus4, disp_Flags,
             disp_rs, disp_rt, disp_rd, disp_rs_ready, disp_rt_ready,
             RegWrite_fMM, WriteRegister_fMM,
      output iq_full, iq_count, iq_empty, Instr_UID_out, Instr_out, Instr_PC_out,
             Instr_PC_Plus4_out, Instr_Flags_out, rs_out, rt_out, rd_out
   );

endinterface

// File: rtl/issue_queue_age_select.sv
// Oldest-ready picker: grants the ready entry that has no older ready entry.
// Purely combinational; the age matrix guarantees at most one grant bit.
module iq_age_select #(
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0]            ready,
   input  logic [DEPTH-1:0][DEPTH-1:0] age,
   output logic [DEPTH-1:0]            grant,
   output logic                        any_ready
);

   always_comb begin
      grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = ready[i] & ~(|(age[i] & ready));
      end
   end

   assign any_ready = |ready;

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: allocate at the edge, issue the oldest ready entry one cycle later at
// the earliest; RegRead never stalls, so whatever is presented at an edge is consumed there.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int NUM_PHYS_REGS = 64
) (
   input logic          CLK,
   input logic          RESET,
   issue_queue_if.slave iq
);

   localparam int IW       = $clog2(DEPTH);
   localparam int CW       = IW + 1;
   localparam int TAG_BITS = $clog2(NUM_PHYS_REGS);

   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0]            rs_rdy_q;
   logic [DEPTH-1:0]            rt_rdy_q;
   logic [DEPTH-1:0][DEPTH-1:0] age_q;
   iq_entry_t                   ent_q [DEPTH];
   logic [CW-1:0]               count_q;

   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] grant;
   logic             any_ready;
   logic             alloc;
   logic             free_found;
   logic [IW-1:0]    free_idx;
   logic             disp_rs_rdy;
   logic             disp_rt_rdy;
   iq_entry_t        sel;

   assign ready = valid_q & rs_rdy_q & rt_rdy_q;

   iq_age_select #(.DEPTH(DEPTH)) u_age_select (
      .ready     (ready),
      .age       (age_q),
      .grant     (grant),
      .any_ready (any_ready)
   );

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx   = IW'(i);
            free_found = 1'b1;
         end
      end
   end

   // Fullness is judged on the registered count, so a same-cycle issue never frees a slot for dispatch.
   assign iq.iq_full  = (count_q == CW'(DEPTH));
   assign iq.iq_count = count_q;
   assign alloc       = iq.disp_valid & ~iq.iq_full & ~iq.flush & free_found;

   // Tag 0 is the hardwired-ready register; a same-cycle writeback also counts as ready.
   assign disp_rs_rdy = iq.disp_rs_ready | (iq.disp_rs[TAG_BITS-1:0] == '0)
                      | wb_hit(iq.RegWrite_fMM, iq.WriteRegister_fMM, iq.disp_rs);
   assign disp_rt_rdy = iq.disp_rt_ready | (iq.disp_rt[TAG_BITS-1:0] == '0)
                      | wb_hit(iq.RegWrite_fMM, iq.WriteRegister_fMM, iq.disp_rt);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q  <= '0;
         rs_rdy_q <= '0;
         rt_rdy_q <= '0;
         age_q    <= '0;
         count_q  <= '0;
      end else if (iq.flush) begin
         valid_q <= '0;
         age_q   <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) valid_q[i] <= 1'b0;
            if (valid_q[i] && wb_hit(iq.RegWrite_fMM, iq.WriteRegister_fMM, ent_q[i].rs))
               rs_rdy_q[i] <= 1'b1;
            if (valid_q[i] && wb_hit(iq.RegWrite_fMM, iq.WriteRegister_fMM, ent_q[i].rt))
               rt_rdy_q[i] <= 1'b1;
            if (alloc) age_q[i][free_idx] <= 1'b0;
         end
         if (alloc) begin
            valid_q[free_idx]  <= 1'b1;
            rs_rdy_q[free_idx] <= disp_rs_rdy;
            rt_rdy_q[free_idx] <= disp_rt_rdy;
            age_q[free_idx]    <= valid_q & ~grant;
         end
         count_q <= count_q + CW'(alloc) - CW'(any_ready);
      end
   end

   always_ff @(posedge CLK) begin
      if (alloc) begin
         ent_q[free_idx] <= '{uid:      iq.disp_UID,
                              instr:    iq.disp_Instr,
                              pc:       iq.disp_PC,
                              pc_plus4: iq.disp_PC_Plus4,
                              flags:    iq.disp_Flags,
                              rs:       iq.disp_rs,
                              rt:       iq.disp_rt,
                              rd:       iq.disp_rd};
      end
   end

   // One-hot AND-OR mux; no grant leaves every field at zero.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel = sel | ent_q[i];
      end
   end

   assign iq.iq_empty           = ~any_ready;
   assign iq.Instr_UID_out      = sel.uid;
   assign iq.Instr_out          = sel.instr;
   assign iq.Instr_PC_out       = sel.pc;
   assign iq.Instr_PC_Plus4_out = sel.pc_plus4;
   assign iq.Instr_Flags_out    = sel.flags;
   assign iq.rs_out             = sel.rs;
   assign iq.rt_out             = sel.rt;
   assign iq.rd_out             = sel.rd;

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Out-of-order issue queue between rename/dispatch and RegRead.
- Buffers renamed instructions, tracks source-operand readiness per physical tag, and wakes sources on the memory-stage writeback broadcast.
- Each cycle, presents the oldest fully-ready instruction to RegRead in exactly the field format RegRead consumes, with iq_empty as the valid qualifier.

Parameters:
- DEPTH, 16, number of queue entries (power of two, 4..32).
- NUM_PHYS_REGS, 64, physical register count; tags are 6 bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; invalidates all entries.
- disp_valid  in  1  dispatch request this cycle.
- disp_UID  in  32  instruction UID.
- disp_Instr  in  32  raw instruction.
- disp_PC  in  32  instruction PC.
- disp_PC_Plus4  in  32  PC+4.
- disp_Flags  in  23  decoded flag bundle; same bit layout RegRead decodes ([22] MemRead … [1:0] MultRegAccess).
- disp_rs  in  6  physical source A tag.
- disp_rt  in  6  physical source B tag.
- disp_rd  in  6  physical destination tag.
- disp_rs_ready  in  1  source A already available, or unused.
- disp_rt_ready  in  1  source B already available, or unused.
- RegWrite_fMM  in  1  writeback valid (wakeup broadcast).
- WriteRegister_fMM  in  6  writeback tag.
- iq_full  out  1  no free entry; dispatch is ignored.
- iq_count  out  $clog2(DEPTH)+1  number of valid entries.
- iq_empty  out  1  high when no entry is ready to issue.
- Instr_UID_out, Instr_out, Instr_PC_out, Instr_PC_Plus4_out  out  32 each  selected entry fields.
- Instr_Flags_out  out  23  selected entry flags.
- rs_out, rt_out, rd_out  out  6 each  selected entry tags.

Behaviour:
- Entry state: valid, rs_rdy, rt_rdy, payload, plus a DEPTH×DEPTH age matrix. age[i][j]=1 means entry j is older than entry i.
- Reset, asynchronous: all valid, rs_rdy, rt_rdy and age bits cleared. Outputs: iq_empty=1, iq_full=0, iq_count=0, all payload outputs 0.
- Ready(i) = valid & rs_rdy & rt_rdy.
- Select (combinational): the unique ready entry i for which no ready j has age[i][j]=1.
  - iq_empty = no entry ready.
  - Output fields drive the selected entry's payload; they are all 0 when iq_empty=1.
- Issue handshake: RegRead has no back-pressure. Whenever iq_empty=0 at a rising edge, the presented entry is consumed and its valid bit clears at that edge. Issue rate is at most one instruction per cycle.
- Dispatch:
  - When disp_valid & ~iq_full, the lowest-index free entry is allocated at the edge.
  - The new entry's age row is set to the current valid vector, excluding the entry issuing this same cycle.
  - Column i is cleared in all rows on allocate.
  - When disp_valid & iq_full, the request is dropped. Dispatch must stall on iq_full.
- iq_full and iq_count are registered state, not combinational from disp_valid.
  - iq_full = (count == DEPTH).
  - count_next = count + alloc − issue. Simultaneous alloc and issue leaves count unchanged.
  - When full, an issue in the same cycle does not make room for a same-cycle dispatch.
- Wakeup: when RegWrite_fMM=1, every valid entry with rs==WriteRegister_fMM sets rs_rdy; likewise for rt. Wakeup takes effect at the edge, so a woken entry can issue the following cycle.
- Dispatch/wakeup race: if the dispatched disp_rs or disp_rt equals WriteRegister_fMM while RegWrite_fMM=1 in the same cycle, the corresponding ready bit is stored as 1.
- Tag 0 is always treated as ready.
- A just-dispatched entry is never selected in its allocation cycle. Earliest issue is the next cycle.
- flush: clears all valid bits, age bits and count at the edge. A same-cycle dispatch is discarded. iq_empty=1 from the next cycle.
- Reset asserted mid-operation: all contents are lost immediately, asynchronously.

Decomposition:
- Shared package holds:
  - IQ_FLAGS_W=23 and the flag bit-position constants, shared with RegRead.
  - PHYS_TAG_W=6.
  - An iq_entry_t payload struct (UID, Instr, PC, PC_Plus4, Flags, rs, rt, rd).
- One sub-module: iq_age_select. It takes the ready vector and the age matrix, and outputs a one-hot grant plus an any-ready signal.

Test Plan:
- Reset, then dispatch UID=1 (rs=5, rt=6, both ready) → iq_empty=0 the next cycle with Instr_UID_out=1; iq_empty=1 the cycle after; iq_count 1→0.
- Dispatch UID=10 (rs=7 not ready), then UID=11 (all ready) → 11 issues first. Drive RegWrite_fMM=1 with WriteRegister_fMM=7 → UID=10 issues one cycle later.
- Dispatch UIDs 20,21,22 all waiting on tag 9, then wake tag 9 → issue order is 20,21,22 on consecutive cycles.
- Dispatch rs=12 while RegWrite_fMM=1 with WriteRegister_fMM=12 in the same cycle → entry issues the next cycle without a further wakeup.
- Fill 16 entries with none ready → iq_full=1 and iq_count=16; a 17th dispatch is dropped. Wake one entry and let it issue → iq_full=0 and iq_count=15.
- 5 entries valid, assert flush together with a dispatch → iq_count=0 and iq_empty=1 afterwards; no stale UID ever appears.
